snoopy_sprite_drawer: RTL and testbench
=======================================

SNOOPY_SPRITE_DRAWER -- requirements
Module: snoopy_sprite_drawer

Interface
REQ-001 The block SHALL have one clock, `clock`, and a synchronous, active-high reset, `reset`.
REQ-002 The block SHALL provide the following parameters:
- `SPRITE_W`, default 16: sprite width in pixels, power of 2.
- `SPRITE_H`, default 16: sprite height in pixels, power of 2.
- `BG_COLOUR`, default 3'b000: colour used when erasing.
- `TRANSPARENT`, default 3'b111: ROM colour that is never plotted.
- `MAX_X`, default 159: last visible column.
- `MAX_Y`, default 119: last visible row.

REQ-003 The block SHALL provide the following ports:
- `clock`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous active-high reset.
- `snoopy_x`, input, 8: requested sprite origin column, from the horizontal FSM.
- `snoopy_y`, input, 7: requested sprite origin row.
- `rom_addr`, output, log2(W*H): sprite ROM address, row-major; rom_addr = cy*SPRITE_W + cx.
- `rom_data`, input, 3: ROM colour, valid exactly 1 cycle after `rom_addr`.
- `vga_x`, output, 8: pixel column to the VGA adapter.
- `vga_y`, output, 7: pixel row to the VGA adapter.
- `vga_colour`, output, 3: pixel colour.
- `vga_plot`, output, 1: write strobe; 1 pixel written per cycle while high.
- `busy`, output, 1: high in every state except IDLE.

Function
REQ-004 The FSM SHALL have the states IDLE, ERASE, DRAW and DONE.
REQ-005 The block SHALL hold registers `drawn_x`/`drawn_y` (position currently on screen), `tgt_x`/`tgt_y` (position being drawn), a `first` flag, and a W*H pixel counter {cy,cx}.
REQ-006 IDLE, when `first`=1: capture `snoopy_x`/`snoopy_y` into tgt, clear the counter, go to DRAW; no erase is performed.
REQ-007 IDLE, when `first`=0 and {snoopy_x,snoopy_y} != {drawn_x,drawn_y}: capture tgt, clear the counter, go to ERASE.
REQ-008 IDLE, when neither condition of REQ-006/REQ-007 holds: remain in IDLE with `vga_plot`=0.
REQ-009 ERASE SHALL take exactly W*H cycles, one pixel per cycle: `vga_x`=drawn_x+cx, `vga_y`=drawn_y+cy, `vga_colour`=BG_COLOUR.
REQ-010 ERASE SHALL go to DRAW with the counter cleared after pixel {H-1,W-1}.
REQ-011 DRAW SHALL issue `rom_addr` for counter values 0..W*H-1 on consecutive cycles, then spend 1 further drain cycle, for W*H+1 cycles total.
REQ-012 The coordinates SHALL be pipelined 1 stage so that `vga_x`/`vga_y`/`vga_colour`/`vga_plot` correspond to the `rom_data` returned for the address issued in the previous cycle.
REQ-013 In DRAW, `vga_colour`=rom_data, and `vga_plot` SHALL be 0 for any pixel where rom_data==TRANSPARENT.
REQ-014 Coordinate sums SHALL be computed 9 bits wide for x and 8 bits wide for y, and `vga_plot` SHALL be forced to 0 for any pixel with x>MAX_X or y>MAX_Y (clipping in both ERASE and DRAW, no wrap-around).
REQ-015 DONE SHALL last 1 cycle: drawn <= tgt, `first` <= 0, `vga_plot`=0, then go to IDLE.
REQ-016 Changes on `snoopy_x`/`snoopy_y` while `busy`=1 SHALL be ignored; the inputs are re-sampled only in IDLE, so intermediate positions may be skipped.
REQ-017 All outputs except `rom_addr` SHALL be registered; `rom_addr` SHALL be a direct function of the counter.
REQ-018 A full move SHALL take 1 (IDLE) + W*H + W*H+1 + 1 cycles, i.e. 515 cycles at 16x16, from the input change to `busy` falling.

Reset
REQ-019 On `reset`=1 at a clock edge: state=IDLE, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0, `busy`=0, counter=0, drawn=0, tgt=0, `first`=1.
REQ-020 A reset asserted mid-ERASE or mid-DRAW SHALL abort with `vga_plot`=0 from the next cycle, and the following draw SHALL be a first draw with no erase of the partially drawn pixels.
REQ-021 With `reset` held high, `vga_plot` SHALL stay 0.

Verification
REQ-022 Reset release with x=0, y=100 and ROM all 3'b010: no erase; exactly 256 plots covering x 0..15, y 100..115, colour 010; `busy` high for 258 cycles.
REQ-023 From IDLE at (0,100), x changes to 1: 256 plots of colour 000 over x 0..15, then 256 plots over x 1..16; afterwards drawn_x=1 and `busy` falls 515 cycles after the change.
REQ-024 First draw at x=150, y=110: exactly 100 plots (x 150..159, y 110..119); no plot with x>159 or y>119.
REQ-025 ROM address 0 = TRANSPARENT, all other entries 3'b100: 255 plots, none at the origin pixel.
REQ-026 x changes 0->1->2 during DRAW: no restart; after DONE, 1 erase of (1,y) and 1 draw at (2,y).
REQ-027 Reset asserted 40 cycles into ERASE: `vga_plot`=0 the next cycle; after release, a first draw is performed at the current inputs with no erase phase.

Source files
------------

// File: rtl/snoopy_sprite_drawer.sv
// ---------------------------------------------------------------------------
// snoopy_sprite_drawer
//
// Moves a SPRITE_W x SPRITE_H sprite around a VGA frame buffer. When the
// requested origin differs from the one on screen, the old footprint is
// painted with BG_COLOUR and the sprite is then redrawn from its ROM at the
// new origin. The very first draw after reset skips the erase. Pixels that
// fall outside 0..MAX_X / 0..MAX_Y are clipped (never plotted, never wrapped),
// and ROM entries equal to TRANSPARENT are never plotted.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous active-high reset
//   snoopy_x/y  requested sprite origin, sampled only while idle
//   rom_addr    sprite ROM address {cy,cx} (row-major), combinational
//   rom_data    ROM colour, valid one cycle after rom_addr
//   vga_x/y     pixel coordinate to the VGA adapter (registered)
//   vga_colour  pixel colour (registered)
//   vga_plot    write strobe, one pixel per cycle while high (registered)
//   busy        high whenever the FSM is not idle (registered)
// ---------------------------------------------------------------------------
module snoopy_sprite_drawer #(
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] TRANSPARENT = 3'b111,
    parameter int         MAX_X       = 159,
    parameter int         MAX_Y       = 119
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [7:0]                            snoopy_x,
    input  logic [6:0]                            snoopy_y,
    output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]  rom_addr,
    input  logic [2:0]                            rom_data,
    output logic [7:0]                            vga_x,
    output logic [6:0]                            vga_y,
    output logic [2:0]                            vga_colour,
    output logic                                  vga_plot,
    output logic                                  busy
);

    localparam int CX_W   = $clog2(SPRITE_W);
    localparam int CY_W   = $clog2(SPRITE_H);
    localparam int ADDR_W = CX_W + CY_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SPRITE_W * SPRITE_H - 1);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t            state, state_nxt;
    logic              load_tgt;
    logic              moved;

    logic [ADDR_W-1:0] cnt;
    logic [CX_W-1:0]   cx;
    logic [CY_W-1:0]   cy;
    logic              drain;
    logic              first;
    logic [7:0]        drawn_x, tgt_x;
    logic [6:0]        drawn_y, tgt_y;

    logic [8:0]        erase_x, draw_x;
    logic [7:0]        erase_y, draw_y;

    logic [8:0]        x_p0;
    logic [7:0]        y_p0;
    logic              vld_p0;

    // Coordinate sums are one bit wider than the screen so that an origin
    // near the right/bottom edge overflows past MAX_X/MAX_Y instead of wrapping.
    function automatic logic [8:0] sum_x(input logic [7:0] base, input logic [CX_W-1:0] off);
        return {1'b0, base} + 9'(off);
    endfunction

    function automatic logic [7:0] sum_y(input logic [6:0] base, input logic [CY_W-1:0] off);
        return {1'b0, base} + 8'(off);
    endfunction

    function automatic logic on_screen(input logic [8:0] x, input logic [7:0] y);
        return (x <= 9'(MAX_X)) && (y <= 8'(MAX_Y));
    endfunction

    assign cx       = cnt[CX_W-1:0];
    assign cy       = cnt[ADDR_W-1:CX_W];
    assign rom_addr = cnt;
    assign moved    = ({snoopy_x, snoopy_y} != {drawn_x, drawn_y});

    assign erase_x  = sum_x(drawn_x, cx);
    assign erase_y  = sum_y(drawn_y, cy);
    assign draw_x   = sum_x(tgt_x, cx);
    assign draw_y   = sum_y(tgt_y, cy);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_tgt  = 1'b0;
        case (state)
            IDLE: begin
                if (first) begin
                    state_nxt = DRAW;
                    load_tgt  = 1'b1;
                end else if (moved) begin
                    state_nxt = ERASE;
                    load_tgt  = 1'b1;
                end
            end
            ERASE: begin
                if (cnt == LAST) begin
                    state_nxt = DRAW;
                end
            end
            DRAW: begin
                if (drain) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Pixel counter and position bookkeeping. The counter wraps to zero
    // naturally after the last pixel because W*H is a power of two; DRAW
    // then spends one drain cycle while the final ROM read returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            drain   <= 1'b0;
            first   <= 1'b1;
            drawn_x <= '0;
            drawn_y <= '0;
            tgt_x   <= '0;
            tgt_y   <= '0;
        end else begin
            drain <= 1'b0;
            case (state)
                IDLE:  cnt <= '0;
                ERASE: cnt <= cnt + ONE;
                DRAW: begin
                    if (!drain) begin
                        cnt   <= cnt + ONE;
                        drain <= (cnt == LAST);
                    end
                end
                DONE: begin
                    drawn_x <= tgt_x;
                    drawn_y <= tgt_y;
                    first   <= 1'b0;
                end
                default: ;
            endcase
            if (load_tgt) begin
                tgt_x <= snoopy_x;
                tgt_y <= snoopy_y;
            end
        end
    end

    // ---- stage p0: coordinates of the ROM address issued this cycle ----
    always_ff @(posedge clock) begin
        x_p0 <= draw_x;
        y_p0 <= draw_y;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= (state == DRAW) && !drain;
        end
    end

    // ---- output stage: rom_data joins the p0 coordinates; erase bypasses ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            if (state == ERASE) begin
                vga_x      <= erase_x[7:0];
                vga_y      <= erase_y[6:0];
                vga_colour <= BG_COLOUR;
                vga_plot   <= on_screen(erase_x, erase_y);
            end else begin
                vga_x      <= x_p0[7:0];
                vga_y      <= y_p0[6:0];
                vga_colour <= rom_data;
                vga_plot   <= vld_p0 && (rom_data != TRANSPARENT) && on_screen(x_p0, y_p0);
            end
        end
    end

endmodule

// File: tb/tb_snoopy_sprite_drawer.sv
module tb_snoopy_sprite_drawer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] snoopy_x = 8'd0;
    logic [6:0] snoopy_y = 7'd0;
    logic [7:0] rom_addr;
    logic [2:0] rom_data;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    snoopy_sprite_drawer dut (
        .clock      (clock),
        .reset      (reset),
        .snoopy_x   (snoopy_x),
        .snoopy_y   (snoopy_y),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Sprite ROM model with one cycle of read latency.
    logic [2:0] rom [256];
    always @(posedge clock) rom_data <= rom[rom_addr];

    int checks   = 0;
    int failures = 0;

    // Per-phase statistics, gathered one sample per cycle just after the edge.
    int bg_n, fg_n, clip_n, origin_n, wrong_n, busy_n;
    int bg_xmin, bg_xmax, fg_xmin, fg_xmax, fg_ymin, fg_ymax;
    logic [2:0] exp_fill;
    int ox, oy;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] fill;
        bit         t0;
        int         plots;
        int         xmin;
        int         xmax;
        int         ymin;
        int         ymax;
        int         origin;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        bg_n = 0; fg_n = 0; clip_n = 0; origin_n = 0; wrong_n = 0; busy_n = 0;
        bg_xmin = 999; bg_xmax = -1;
        fg_xmin = 999; fg_xmax = -1; fg_ymin = 999; fg_ymax = -1;
    endtask

    task automatic fill_rom(input logic [2:0] fill, input bit t0);
        for (int a = 0; a < 256; a++) rom[a] = fill;
        if (t0) rom[0] = 3'b111;
        exp_fill = fill;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (busy) busy_n++;
        if (vga_plot) begin
            if (vga_x > 8'd159 || vga_y > 7'd119) clip_n++;
            if (vga_colour == 3'b000) begin
                bg_n++;
                if (int'(vga_x) < bg_xmin) bg_xmin = int'(vga_x);
                if (int'(vga_x) > bg_xmax) bg_xmax = int'(vga_x);
            end else begin
                fg_n++;
                if (int'(vga_x) < fg_xmin) fg_xmin = int'(vga_x);
                if (int'(vga_x) > fg_xmax) fg_xmax = int'(vga_x);
                if (int'(vga_y) < fg_ymin) fg_ymin = int'(vga_y);
                if (int'(vga_y) > fg_ymax) fg_ymax = int'(vga_y);
                if (vga_colour != exp_fill) wrong_n++;
                if (int'(vga_x) == ox && int'(vga_y) == oy) origin_n++;
            end
        end
    endtask

    // Runs until busy has risen and fallen again; n counts clock edges.
    task automatic run_move(input int inject_at, input logic [7:0] inject_x, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 1200; i++) begin
            step();
            n++;
            if (n == inject_at) snoopy_x = inject_x;
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        chk("move_completes", (seen && !busy) ? 1 : 0, 1);
    endtask

    task automatic first_draw(input logic [7:0] x, input logic [6:0] y);
        int n;
        reset = 1'b1;
        snoopy_x = x;
        snoopy_y = y;
        step();
        step();
        reset = 1'b0;
        run_move(-1, 8'd0, n);
    endtask

    initial begin
        int n;

        vt[0] = '{0,   100, 3'b010, 1'b0, 256, 0,   15,  100, 115, 1};
        vt[1] = '{150, 110, 3'b010, 1'b0, 100, 150, 159, 110, 119, 1};
        vt[2] = '{20,  30,  3'b100, 1'b1, 255, 20,  35,  30,  45,  0};
        vt[3] = '{155, 0,   3'b001, 1'b0, 80,  155, 159, 0,   15,  1};
        vt[4] = '{0,   119, 3'b011, 1'b0, 16,  0,   15,  119, 119, 1};

        // Reset state
        fill_rom(3'b010, 1'b0);
        reset = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) step();
        chk("rst_plot",   int'(vga_plot),   0);
        chk("rst_x",      int'(vga_x),      0);
        chk("rst_y",      int'(vga_y),      0);
        chk("rst_colour", int'(vga_colour), 0);
        chk("rst_busy",   int'(busy),       0);
        chk("rst_addr",   int'(rom_addr),   0);
        chk("rst_no_plots", bg_n + fg_n, 0);

        // First draws straight out of reset
        for (int i = 0; i < 5; i++) begin
            fill_rom(vt[i].fill, vt[i].t0);
            reset = 1'b1;
            snoopy_x = 8'(vt[i].x);
            snoopy_y = 7'(vt[i].y);
            ox = vt[i].x;
            oy = vt[i].y;
            step();
            step();
            clear_stats();
            reset = 1'b0;
            run_move(-1, 8'd0, n);
            for (int k = 0; k < 3; k++) step();
            chk($sformatf("v%0d_plots", i),  fg_n,    vt[i].plots);
            chk($sformatf("v%0d_erase", i),  bg_n,    0);
            chk($sformatf("v%0d_xmin", i),   fg_xmin, vt[i].xmin);
            chk($sformatf("v%0d_xmax", i),   fg_xmax, vt[i].xmax);
            chk($sformatf("v%0d_ymin", i),   fg_ymin, vt[i].ymin);
            chk($sformatf("v%0d_ymax", i),   fg_ymax, vt[i].ymax);
            chk($sformatf("v%0d_origin", i), origin_n, vt[i].origin);
            chk($sformatf("v%0d_colour", i), wrong_n, 0);
            chk($sformatf("v%0d_clip", i),   clip_n,  0);
            chk($sformatf("v%0d_busy", i),   busy_n,  258);
        end

        // Move 0 -> 1, with a further change to 2 mid-DRAW that must not restart
        fill_rom(3'b010, 1'b0);
        ox = -1;
        oy = -1;
        first_draw(8'd0, 7'd100);
        snoopy_x = 8'd1;
        clear_stats();
        run_move(300, 8'd2, n);
        chk("m1_latency", n,       515);
        chk("m1_erase",   bg_n,    256);
        chk("m1_e_xmin",  bg_xmin, 0);
        chk("m1_e_xmax",  bg_xmax, 15);
        chk("m1_draw",    fg_n,    256);
        chk("m1_d_xmin",  fg_xmin, 1);
        chk("m1_d_xmax",  fg_xmax, 16);

        // The skipped-to position is picked up once the move completes
        clear_stats();
        run_move(-1, 8'd0, n);
        chk("m2_erase",   bg_n,    256);
        chk("m2_e_xmin",  bg_xmin, 1);
        chk("m2_e_xmax",  bg_xmax, 16);
        chk("m2_draw",    fg_n,    256);
        chk("m2_d_xmin",  fg_xmin, 2);
        chk("m2_d_xmax",  fg_xmax, 17);
        chk("m2_busy",    busy_n,  514);
        clear_stats();
        for (int k = 0; k < 20; k++) step();
        chk("m2_settled", busy_n + bg_n + fg_n, 0);

        // Clipped erase and draw near the right/bottom edge
        first_draw(8'd150, 7'd110);
        snoopy_x = 8'd151;
        clear_stats();
        run_move(-1, 8'd0, n);
        chk("edge_erase", bg_n,    100);
        chk("edge_e_xmax", bg_xmax, 159);
        chk("edge_draw",  fg_n,    90);
        chk("edge_d_xmin", fg_xmin, 151);
        chk("edge_clip",  clip_n,  0);

        // Reset 40 cycles into ERASE aborts; next draw is a first draw
        first_draw(8'd0, 7'd100);
        snoopy_x = 8'd1;
        for (int k = 0; k < 41; k++) step();
        chk("abort_erasing", int'(vga_plot), 1);
        reset = 1'b1;
        step();
        chk("abort_plot", int'(vga_plot), 0);
        chk("abort_busy", int'(busy), 0);
        clear_stats();
        for (int k = 0; k < 5; k++) step();
        chk("abort_held", bg_n + fg_n, 0);
        clear_stats();
        reset = 1'b0;
        run_move(-1, 8'd0, n);
        chk("abort_no_erase", bg_n,    0);
        chk("abort_draw",     fg_n,    256);
        chk("abort_xmin",     fg_xmin, 1);
        chk("abort_xmax",     fg_xmax, 16);
        chk("abort_busy_len", busy_n,  258);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
